fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage controller. It owns the PC and the IF/ID pipeline register, and issues requests to a variable-latency instruction memory over a request/acknowledge handshake. It applies the controller's redirect (`PCSrc`) and `flush` decisions, and honours the hazard unit's `stall`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  1  from hazard unit; 1 = hold PC and IF/ID.
- `flush`  in  1  from controller; 1 = squash IF/ID (taken beq/bne).
- `PCSrc`  in  2  from controller.
  - 00 = sequential.
  - 01 = branch.
  - 10 = jump.
  - 11 = treated as 00.
- `branchTarget`  in  32  ID-stage branch address.
- `jumpTarget`  in  32  ID-stage jump address, already 32-bit.
- `imReq`  out  1  instruction-memory request.
- `imAddr`  out  32  request address; equals `pc`.
- `imAck`  in  1  memory returns `imData` this cycle.
- `imData`  in  32  instruction word, valid only with `imAck`.
- `pc`  out  32  current fetch PC.
- `instr`  out  32  IF/ID instruction (32'h0 = NOP bubble).
- `pcPlus4`  out  32  IF/ID PC+4 of `instr`.
- `valid`  out  1  IF/ID holds a real instruction.

## Operation
- `redirect` = `stall`==0 && (`PCSrc`==01 || `PCSrc`==10); target is `branchTarget` or `jumpTarget` respectively.
- `squash` = `stall`==0 && (`flush` || `PCSrc`==10). Jump squashes even though the controller does not raise `flush` for it.
- While `stall`==1, `PCSrc` and `flush` are ignored.
- Bubble = `instr`=0, `pcPlus4`=0, `valid`=0.
- Memory protocol: once `imReq` is raised, `imAddr` stays constant until the cycle `imAck`=1. Only one request is outstanding at a time. `imAck` may arrive in the same cycle as the request is raised (0-wait) or any number of cycles later.
- States: REQ, DROP, HELD. The block has an internal 32-bit hold buffer and a 32-bit saved-target register.
- REQ (`imReq`=1):
  - `redirect` (with or without `imAck`):
    - Any acked data is discarded and IF/ID ← bubble.
    - If `imAck`: `pc` ← target; stay in REQ.
    - If no `imAck`: saved target ← target; go to DROP; `pc` is unchanged.
  - `imAck` && `stall`==0 && !`redirect`:
    - IF/ID ← {`imData`, `pc`+4, valid=1}.
    - `pc` ← `pc`+4.
    - `squash` without `redirect` cannot occur; if it does, squash wins and IF/ID ← bubble while `pc` still advances.
  - `imAck` && `stall`==1: hold buffer ← `imData`; go to HELD; `pc` and IF/ID are held.
  - No `imAck`: IF/ID ← bubble if `stall`==0, held if `stall`==1.
- DROP (`imReq`=1, same address):
  - A new `redirect` overwrites the saved target; latest wins.
  - On `imAck`: data is discarded; `pc` ← saved target (or the same-cycle `redirect` target); go to REQ.
  - IF/ID: bubble when `stall`==0, held when `stall`==1.
- HELD (`imReq`=0):
  - `stall`==1: hold.
  - `stall`==0 && `redirect`: discard buffer; `pc` ← target; IF/ID ← bubble; go to REQ.
  - `stall`==0 otherwise: IF/ID ← {buffer, `pc`+4, 1}; `pc` ← `pc`+4; go to REQ.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0, no flag.
- Reset (`rst`==0 at an edge, in any state, including mid-request):
  - `pc` ← `RESET_PC`; IF/ID ← bubble; state ← REQ.
  - Any outstanding memory response is not tracked: the memory is reset by the same `rst`.
  - `imReq` is forced to 0 in any cycle in which `rst`==0.

## Timing
- `pc`, `instr`, `pcPlus4`, `valid` and the state are registered.
- `imReq` and `imAddr` are decoded from state and `pc`; they do not depend combinationally on `imAck`.
- Fetch latency: instruction appears in IF/ID on the edge at which `imAck`=1 (when not stalled). With a 0-wait memory, throughput is one instruction per cycle.
- Redirect: the edge at which `redirect` is seen updates `pc` (REQ-with-ack and HELD cases) and writes a bubble. The target is requested in the following cycle.
- Redirect penalty with a 0-wait memory: 1 bubble.
- Reset values: `pc`=`RESET_PC`, `instr`=0, `pcPlus4`=0, `valid`=0, `imReq`=0 (while `rst`=0), state=REQ.
- First request: `imReq`=1 in the first cycle with `rst`=1.

## Test plan
- Reset, then a 0-wait memory returning `addr`+32'h100: `instr` is 32'h100, 32'h104, 32'h108 on consecutive edges; `pcPlus4` is 4, 8, C; `valid`=1.
- 2-wait memory: `imReq` high with `imAddr`=0 for 3 cycles, 2 bubbles; then `instr` is valid with `pcPlus4`=4.
- Stall with ack at `pc`=8: state HELD, `imReq`=0, IF/ID unchanged. Stall drops for 3 cycles: IF/ID = {data@8, 32'hC, 1}, then the fetch of 32'hC.
- beq taken (`PCSrc`=01, `flush`=1, `branchTarget`=32'h40) during a 3-wait request at `pc`=10:
  - `imAddr` stays 10 until ack; that data is dropped.
  - Next request has `imAddr`=40; `valid`=0 throughout.
- Jump (`PCSrc`=10, `flush`=0, `jumpTarget`=32'h200) with 0-wait memory: one bubble, then `pcPlus4`=204. `PCSrc`=01 together with `stall`=1 is ignored.
- `rst`=0 asserted mid-DROP at `pc`=20: next edge `pc`=`RESET_PC`, `valid`=0, `imReq`=0. Wrap test: `RESET_PC`=32'hFFFF_FFFC fetches 32'hFFFF_FFFC then 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID register, and fetches from a variable-latency
// instruction memory. Applies ID-stage redirects/flushes and honours stall.
//
// Memory handshake: imReq is the request valid and imAck is the response
// strobe. While imReq is high, imAddr is held constant until the cycle in
// which imAck=1; that cycle completes the transfer, and imData is sampled
// only in that cycle. Only one request is ever outstanding.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] branchTarget,
   input  logic [31:0] jumpTarget,
   output logic        imReq,
   output logic [31:0] imAddr,
   input  logic        imAck,
   input  logic [31:0] imData,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] pcPlus4,
   output logic        valid,
   output logic [1:0]  dbg_state
);

   // REQ: request in flight at pc. DROP: request in flight whose data must
   // be discarded (a redirect arrived before the ack). HELD: a word was
   // acked during a stall and is parked in hold_buf.
   localparam logic [1:0] REQ  = 2'd0;
   localparam logic [1:0] DROP = 2'd1;
   localparam logic [1:0] HELD = 2'd2;

   logic [1:0]  state;
   logic [31:0] hold_buf;
   logic [31:0] saved_tgt;
   logic [31:0] pc_seq;
   logic [31:0] target;
   logic        redirect;
   logic        squash;

   // Controller decisions are only honoured when the hazard unit is not stalling.
   always_comb begin
      redirect = ~stall & ((PCSrc == 2'b01) | (PCSrc == 2'b10));
      squash   = ~stall & (flush | (PCSrc == 2'b10));
      target   = (PCSrc == 2'b10) ? jumpTarget : branchTarget;
      pc_seq   = pc + 32'd4;
   end

   // Request is decoded from state only, so it never depends on imAck.
   assign imReq     = rst & (state != HELD);
   assign imAddr    = pc;
   assign dbg_state = state;

   // PC, IF/ID register and fetch-state sequencing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc        <= RESET_PC;
         instr     <= 32'h0;
         pcPlus4   <= 32'h0;
         valid     <= 1'b0;
         state     <= REQ;
         hold_buf  <= 32'h0;
         saved_tgt <= 32'h0;
      end else begin
         case (state)
            REQ: begin
               if (redirect) begin
                  instr   <= 32'h0;
                  pcPlus4 <= 32'h0;
                  valid   <= 1'b0;
                  if (imAck) begin
                     pc <= target;
                  end else begin
                     // Address must stay put until the ack; remember where to go.
                     saved_tgt <= target;
                     state     <= DROP;
                  end
               end else if (imAck && !stall) begin
                  pc <= pc_seq;
                  if (squash) begin
                     instr   <= 32'h0;
                     pcPlus4 <= 32'h0;
                     valid   <= 1'b0;
                  end else begin
                     instr   <= imData;
                     pcPlus4 <= pc_seq;
                     valid   <= 1'b1;
                  end
               end else if (imAck) begin
                  hold_buf <= imData;
                  state    <= HELD;
               end else if (!stall) begin
                  instr   <= 32'h0;
                  pcPlus4 <= 32'h0;
                  valid   <= 1'b0;
               end
            end
            DROP: begin
               if (!stall) begin
                  instr   <= 32'h0;
                  pcPlus4 <= 32'h0;
                  valid   <= 1'b0;
               end
               if (imAck) begin
                  pc    <= redirect ? target : saved_tgt;
                  state <= REQ;
               end else if (redirect) begin
                  saved_tgt <= target;
               end
            end
            HELD: begin
               if (!stall) begin
                  state <= REQ;
                  if (redirect) begin
                     pc      <= target;
                     instr   <= 32'h0;
                     pcPlus4 <= 32'h0;
                     valid   <= 1'b0;
                  end else begin
                     pc      <= pc_seq;
                     instr   <= hold_buf;
                     pcPlus4 <= pc_seq;
                     valid   <= 1'b1;
                  end
               end
            end
            default: state <= REQ;
         endcase
      end
   end

endmodule
